// File: rtl/tlb_mp.sv
// tlb_mp: multi-port, fully-associative TLB with one shared Wishbone classic
// refill engine.
//
// Every cycle all PORTS lookup channels are compared against every entry.
// Hits answer one cycle after the request. When at least one requesting port
// misses, one of the missing ports is picked round-robin. Its VPN is latched
// and its PTE is read from PTE_BASE + {vpn,2'b00}. Any other missing port is
// dropped and must request again once req_ready returns.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   hold                 freezes all state; resp_valid is masked while high
//   flush                invalidates entries (the write of an in-flight refill
//                        is suppressed)
//   req_valid/req_vpn    per-port lookup; port p uses req_vpn[p*VPN_W +: VPN_W]
//   req_ready            high only in IDLE without hold
//   resp_valid/hit/fault per-port one-cycle response strobes
//   resp_tag             per-port {ppn, flags}; zero unless resp_hit
//   busy                 a refill is in progress
//   wb_*                 Wishbone classic single-read master
//
// Optional build macro: TLB_ASID_EN. It adds parameter ASID_W and input asid.
// Each entry then also stores an ASID and the global bit PTE[5]. A lookup hits
// only when the VPN matches and either the ASID matches or the entry is global.
// flush then clears only the non-global entries of the current ASID.
module tlb_mp #(
    parameter int          VPN_W    = 20,
    parameter int          PPN_W    = 22,
    parameter int          FLG_W    = 4,
    parameter int          ENTRIES  = 16,
    parameter int          PORTS    = 2,
    parameter logic [31:0] PTE_BASE = 32'h0
`ifdef TLB_ASID_EN
    ,
    parameter int          ASID_W   = 9
`endif
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             hold,
    input  logic                             flush,
`ifdef TLB_ASID_EN
    input  logic [ASID_W-1:0]                asid,
`endif
    input  logic [PORTS-1:0]                 req_valid,
    input  logic [PORTS*VPN_W-1:0]           req_vpn,
    output logic                             req_ready,
    output logic [PORTS-1:0]                 resp_valid,
    output logic [PORTS-1:0]                 resp_hit,
    output logic [PORTS-1:0]                 resp_fault,
    output logic [PORTS*(PPN_W+FLG_W)-1:0]   resp_tag,
    output logic                             busy,
    output logic                             wb_cyc_o,
    output logic                             wb_stb_o,
    output logic                             wb_we_o,
    output logic [3:0]                       wb_sel_o,
    output logic [2:0]                       wb_cti_o,
    output logic [1:0]                       wb_bte_o,
    output logic [31:0]                      wb_adr_o,
    input  logic [31:0]                      wb_dat_i,
    input  logic                             wb_ack_i,
    input  logic                             wb_err_i,
    input  logic                             wb_rty_i
);

    localparam int TAG_W = PPN_W + FLG_W;
    localparam int IW    = $clog2(ENTRIES);
    localparam int PW    = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FILL, S_RESP} state_t;

    state_t             state;
    logic [ENTRIES-1:0] ent_valid;
    logic [VPN_W-1:0]   ent_vpn [ENTRIES];
    logic [TAG_W-1:0]   ent_tag [ENTRIES];
`ifdef TLB_ASID_EN
    logic [ASID_W-1:0]  ent_asid [ENTRIES];
    logic [ENTRIES-1:0] ent_g;
`endif
    logic [IW-1:0]      victim;
    logic [PW-1:0]      last_port;     // port being / last serviced by a refill
    logic [VPN_W-1:0]   fill_vpn;
    logic [31:0]        pte_q;
    logic               fault_q;
    logic               flushed_q;     // a flush was seen during this refill
    logic [PORTS-1:0]   resp_valid_q;

    logic [VPN_W-1:0]   port_vpn [PORTS];
    logic [PORTS-1:0]   port_hit;
    logic [TAG_W-1:0]   port_tag [PORTS];
    logic [ENTRIES-1:0] ctx_ok;
    logic               sel_found;
    logic [PW-1:0]      sel_port;
    logic [VPN_W-1:0]   sel_vpn;
    logic               dup_hit, inv_hit;
    logic [IW-1:0]      dup_idx, inv_idx, fill_idx;
    logic               fill_we;
    logic [TAG_W-1:0]   pte_tag;
    logic               unused_pte;

    assign pte_tag    = {pte_q[10 +: PPN_W], pte_q[FLG_W-1:0]};
    assign unused_pte = ^pte_q[9:FLG_W];
    assign fill_we    = (state == S_FILL) && pte_q[0] && !flush && !flushed_q;

`ifdef TLB_ASID_EN
    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            ctx_ok[e] = ent_g[e] || (ent_asid[e] == asid);
        end
    end
`else
    assign ctx_ok = '1;
`endif

    // Parallel CAM search. A VPN is never stored twice, so OR-ing the matching
    // tags selects the single hit.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            port_vpn[p] = req_vpn[p*VPN_W +: VPN_W];
            port_hit[p] = 1'b0;
            port_tag[p] = '0;
            for (int e = 0; e < ENTRIES; e++) begin
                if (ent_valid[e] && ctx_ok[e] && (ent_vpn[e] == port_vpn[p])) begin
                    port_hit[p] = 1'b1;
                    port_tag[p] = port_tag[p] | ent_tag[e];
                end
            end
        end
    end

    // Round-robin choice among the missing ports, starting after last_port.
    always_comb begin
        sel_found = 1'b0;
        sel_port  = last_port;
        sel_vpn   = port_vpn[0];
        for (int i = 1; i <= PORTS; i++) begin
            if (!sel_found && req_valid[(int'(last_port) + i) % PORTS]
                           && !port_hit[(int'(last_port) + i) % PORTS]) begin
                sel_found = 1'b1;
                sel_port  = PW'((int'(last_port) + i) % PORTS);
                sel_vpn   = port_vpn[(int'(last_port) + i) % PORTS];
            end
        end
    end

    // Fill slot: rewrite an existing copy first, then the lowest invalid
    // entry, then the round-robin victim.
    always_comb begin
        dup_hit = 1'b0;
        dup_idx = '0;
        inv_hit = 1'b0;
        inv_idx = '0;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (ent_valid[e] && ctx_ok[e] && (ent_vpn[e] == fill_vpn)) begin
                dup_hit = 1'b1;
                dup_idx = IW'(e);
            end
            if (!ent_valid[e]) begin
                inv_hit = 1'b1;
                inv_idx = IW'(e);
            end
        end
        fill_idx = dup_hit ? dup_idx : (inv_hit ? inv_idx : victim);
    end

    // Control state: FSM, valid bits, replacement pointer, responses, bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ent_valid    <= '0;
            victim       <= '0;
            last_port    <= '0;
            fault_q      <= 1'b0;
            flushed_q    <= 1'b0;
            resp_valid_q <= '0;
            resp_hit     <= '0;
            resp_fault   <= '0;
            resp_tag     <= '0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_adr_o     <= '0;
        end else if (!hold) begin
            resp_valid_q <= '0;
            resp_hit     <= '0;
            resp_fault   <= '0;
            resp_tag     <= '0;
            case (state)
                S_IDLE: begin
                    for (int p = 0; p < PORTS; p++) begin
                        if (req_valid[p] && port_hit[p]) begin
                            resp_valid_q[p]             <= 1'b1;
                            resp_hit[p]                 <= 1'b1;
                            resp_tag[p*TAG_W +: TAG_W]  <= port_tag[p];
                        end
                    end
                    if (sel_found) begin
                        state     <= S_FETCH;
                        last_port <= sel_port;
                        flushed_q <= 1'b0;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        wb_adr_o  <= PTE_BASE + 32'({sel_vpn, 2'b00});
                    end
                end
                S_FETCH: begin
                    if (flush) flushed_q <= 1'b1;
                    // Terminations only count while stb is up; err beats rty beats ack.
                    if (wb_stb_o) begin
                        if (wb_err_i) begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            fault_q  <= 1'b1;
                            state    <= S_RESP;
                        end else if (wb_rty_i) begin
                            wb_stb_o <= 1'b0;
                        end else if (wb_ack_i) begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            state    <= S_FILL;
                        end
                    end else begin
                        wb_stb_o <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (!pte_q[0]) begin
                        fault_q <= 1'b1;
                    end else if (fill_we) begin
                        ent_valid[fill_idx] <= 1'b1;
                        victim              <= victim + 1'b1;
                    end
                    state <= S_RESP;
                end
                default: begin
                    resp_valid_q[last_port]                  <= 1'b1;
                    resp_hit[last_port]                      <= !fault_q;
                    resp_fault[last_port]                    <= fault_q;
                    resp_tag[int'(last_port)*TAG_W +: TAG_W] <= fault_q ? '0 : pte_tag;
                    fault_q <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
            if (flush) begin
`ifdef TLB_ASID_EN
                for (int e = 0; e < ENTRIES; e++) begin
                    if (!ent_g[e] && (ent_asid[e] == asid)) ent_valid[e] <= 1'b0;
                end
`else
                ent_valid <= '0;
`endif
            end
        end
    end

    // Entry payload and refill data registers (no reset; qualified by valid bits).
    always_ff @(posedge clk) begin
        if (!hold) begin
            if ((state == S_IDLE) && sel_found) fill_vpn <= sel_vpn;
            if ((state == S_FETCH) && wb_stb_o && wb_ack_i && !wb_err_i && !wb_rty_i)
                pte_q <= wb_dat_i;
            if (fill_we) begin
                ent_vpn[fill_idx]  <= fill_vpn;
                ent_tag[fill_idx]  <= pte_tag;
`ifdef TLB_ASID_EN
                ent_asid[fill_idx] <= asid;
                ent_g[fill_idx]    <= pte_q[5];
`endif
            end
        end
    end

    assign req_ready  = (state == S_IDLE) && !hold;
    assign busy       = (state != S_IDLE);
    assign resp_valid = resp_valid_q & {PORTS{!hold}};
    assign wb_we_o    = 1'b0;
    assign wb_sel_o   = 4'hF;
    assign wb_cti_o   = 3'b111;
    assign wb_bte_o   = 2'b00;

endmodule

// File: tb/tb_tlb_mp.sv
// tb_tlb_mp: self-checking bench for tlb_mp with the default parameters.
// Directed scenarios are followed by a randomized run checked against a
// behavioural TLB model kept in this file.
module tb_tlb_mp;

    localparam int VPN_W   = 20;
    localparam int TAG_W   = 26;
    localparam int ENTRIES = 16;
    localparam int PORTS   = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     hold = 1'b0;
    logic                     flush = 1'b0;
    logic [PORTS-1:0]         req_valid = '0;
    logic [PORTS*VPN_W-1:0]   req_vpn = '0;
    logic                     req_ready;
    logic [PORTS-1:0]         resp_valid, resp_hit, resp_fault;
    logic [PORTS*TAG_W-1:0]   resp_tag;
    logic                     busy;
    logic                     wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]               wb_sel_o;
    logic [2:0]               wb_cti_o;
    logic [1:0]               wb_bte_o;
    logic [31:0]              wb_adr_o;
    logic [31:0]              wb_dat_i = '0;
    logic                     wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

    int checks = 0;
    int passes = 0;

    // Behavioural model state.
    bit               m_valid [ENTRIES];
    logic [VPN_W-1:0] m_vpn   [ENTRIES];
    logic [TAG_W-1:0] m_tag   [ENTRIES];
    int               m_ptr;
    int               m_last;

    always #5 clk = ~clk;

    tlb_mp dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .req_valid(req_valid), .req_vpn(req_vpn), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_fault(resp_fault),
        .resp_tag(resp_tag), .busy(busy),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int e = 0; e < ENTRIES; e++) m_valid[e] = 1'b0;
        m_ptr = 0; m_last = 0;
    endtask

    // Slave side: wait for a strobe, stall `gap` cycles, terminate (0 ack, 1 err).
    task automatic wb_respond(input int gap, input int term, input logic [31:0] data);
        int n = 0;
        while (!(wb_cyc_o && wb_stb_o) && n < 50) begin tick(); n++; end
        if (n >= 50) begin
            checks++;
            $display("FAIL wb_strobe_wait: no strobe within 50 cycles, required cyc=stb=1");
        end
        repeat (gap) tick();
        wb_dat_i = data;
        if (term == 1) wb_err_i = 1'b1; else wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (resp_valid != '0) begin lat = n; break; end
        end
    endtask

    function automatic logic [31:0] pte_of(input logic [VPN_W-1:0] v);
        logic [21:0] ppn;
        ppn = {2'b01, v} ^ 22'h15A5A;
        return {ppn, 6'b000000, v[2:0], (v % 7 != 0)};
    endfunction

    function automatic int model_find(input logic [VPN_W-1:0] v);
        for (int e = 0; e < ENTRIES; e++) if (m_valid[e] && m_vpn[e] == v) return e;
        return -1;
    endfunction

    function automatic void model_fill(input logic [VPN_W-1:0] v, input logic [31:0] pte);
        int idx;
        idx = model_find(v);
        if (idx < 0) for (int e = ENTRIES - 1; e >= 0; e--) if (!m_valid[e]) idx = e;
        if (idx < 0) idx = m_ptr;
        m_valid[idx] = 1'b1; m_vpn[idx] = v; m_tag[idx] = {pte[31:10], pte[3:0]};
        m_ptr = (m_ptr + 1) % ENTRIES;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if ({resp_valid, resp_hit, resp_fault, busy, wb_cyc_o, wb_stb_o, req_ready} !== 12'b000000_000_001)
            $display("FAIL reset_ctrl: got v=%b h=%b f=%b busy=%b cyc=%b stb=%b rdy=%b, required zeros and rdy=1",
                     resp_valid, resp_hit, resp_fault, busy, wb_cyc_o, wb_stb_o, req_ready);
        else passes++;
        checks++;
        if ({wb_adr_o, resp_tag} !== '0) $display("FAIL reset_data: got adr=%h tag=%h, required 0", wb_adr_o, resp_tag);
        else passes++;
        checks++;
        if ({wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o} !== {1'b0, 4'hF, 3'b111, 2'b00})
            $display("FAIL wb_static: got we=%b sel=%h cti=%b bte=%b", wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o);
        else passes++;
    endtask

    task automatic test_first_miss();
        int lat;
        req_vpn = {20'h0, 20'h12345}; req_valid = 2'b01;
        tick();
        req_valid = '0;
        checks++;
        if ({busy, wb_cyc_o, wb_stb_o, req_ready, resp_valid} !== 6'b1110_00)
            $display("FAIL miss_start: got busy=%b cyc=%b stb=%b rdy=%b v=%b, required 1 1 1 0 00",
                     busy, wb_cyc_o, wb_stb_o, req_ready, resp_valid);
        else passes++;
        checks++;
        if (wb_adr_o !== 32'h00048D14) $display("FAIL miss_adr: got %h required 00048d14", wb_adr_o);
        else passes++;
        wb_respond(0, 0, 32'h0ABCD00F);
        wait_resp(lat);
        checks++;
        if (lat !== 2) $display("FAIL miss_latency: got %0d required 2", lat);
        else passes++;
        checks++;
        if ({resp_valid, resp_hit, resp_fault, resp_tag[0 +: TAG_W]} !== {6'b01_01_00, 26'h2AF34F})
            $display("FAIL miss_resp: got v=%b h=%b f=%b tag=%h required 01 01 00 2af34f",
                     resp_valid, resp_hit, resp_fault, resp_tag[0 +: TAG_W]);
        else passes++;
    endtask

    task automatic test_multi_hit();
        req_vpn = {20'h12345, 20'h12345}; req_valid = 2'b11;
        tick();
        req_valid = '0;
        checks++;
        if ({resp_valid, resp_hit, wb_cyc_o, busy} !== 6'b11_11_00)
            $display("FAIL dual_hit: got v=%b h=%b cyc=%b busy=%b required 11 11 0 0", resp_valid, resp_hit, wb_cyc_o, busy);
        else passes++;
        checks++;
        if (resp_tag !== {26'h2AF34F, 26'h2AF34F}) $display("FAIL dual_tag: got %h", resp_tag);
        else passes++;
    endtask

    task automatic test_rst_refill();
        int seen = 0;
        req_vpn = {20'h0, 20'h0F00D}; req_valid = 2'b01;
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({wb_cyc_o, wb_stb_o, busy, req_ready} !== 4'b0001)
            $display("FAIL rst_refill: got cyc=%b stb=%b busy=%b rdy=%b required 0 0 0 1", wb_cyc_o, wb_stb_o, busy, req_ready);
        else passes++;
        wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
        tick();
        wb_ack_i = 1'b0;
        repeat (4) begin tick(); if (resp_valid != '0) seen++; end
        checks++;
        if (seen !== 0) $display("FAIL rst_no_resp: got %0d responses required 0", seen);
        else passes++;
        do_reset();
    endtask

    task automatic test_replacement();
        int lat;
        logic [VPN_W-1:0] v [17];
        logic [31:0] pte [17];
        do_reset();
        for (int i = 0; i < 17; i++) begin
            v[i] = VPN_W'(20'h00100 + i * 20'h00013);
            pte[i] = {22'(i * 3 + 1), 6'b0, 4'b0011};
            req_vpn = {20'h0, v[i]}; req_valid = 2'b01;
            tick();
            req_valid = '0;
            wb_respond(0, 0, pte[i]);
            wait_resp(lat);
            checks++;
            if ({resp_hit[0], resp_tag[0 +: TAG_W]} !== {1'b1, pte[i][31:10], pte[i][3:0]})
                $display("FAIL fill_%0d: got hit=%b tag=%h", i, resp_hit[0], resp_tag[0 +: TAG_W]);
            else passes++;
        end
        req_vpn = {20'h0, v[0]}; req_valid = 2'b01;
        tick();
        req_valid = '0;
        checks++;
        if ({busy, resp_valid} !== 3'b1_00) $display("FAIL evicted_miss: got busy=%b v=%b required 1 00", busy, resp_valid);
        else passes++;
        wb_respond(0, 1, 32'h0);
        wait_resp(lat);
        for (int i = 1; i < 17; i += 2) begin
            req_vpn = {v[i+1], v[i]}; req_valid = 2'b11;
            tick();
            req_valid = '0;
            checks++;
            if ({resp_hit, busy, resp_tag} !== {2'b11, 1'b0, pte[i+1][31:10], pte[i+1][3:0], pte[i][31:10], pte[i][3:0]})
                $display("FAIL kept_%0d: got h=%b busy=%b tag=%h", i, resp_hit, busy, resp_tag);
            else passes++;
        end
    endtask

    task automatic test_retry();
        int lat;
        req_vpn = {20'h0ABCD, 20'h0}; req_valid = 2'b10;
        tick();
        req_valid = '0;
        checks++;
        if (wb_adr_o !== 32'h0002AF34) $display("FAIL retry_adr: got %h required 0002af34", wb_adr_o);
        else passes++;
        for (int r = 0; r < 2; r++) begin
            wb_rty_i = 1'b1;
            tick();
            wb_rty_i = 1'b0;
            checks++;
            if ({wb_cyc_o, wb_stb_o} !== 2'b10) $display("FAIL retry_gap_%0d: got cyc=%b stb=%b required 1 0", r, wb_cyc_o, wb_stb_o);
            else passes++;
            tick();
            checks++;
            if ({wb_cyc_o, wb_stb_o} !== 2'b11) $display("FAIL retry_restb_%0d: got cyc=%b stb=%b required 1 1", r, wb_cyc_o, wb_stb_o);
            else passes++;
        end
        wb_dat_i = 32'h7654_3C05; wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        wait_resp(lat);
        checks++;
        if ({lat == 2, resp_valid, resp_hit, resp_tag[TAG_W +: TAG_W]} !== {1'b1, 4'b1010, 22'h1D950F, 4'h5})
            $display("FAIL retry_resp: got lat=%0d v=%b h=%b tag=%h", lat, resp_valid, resp_hit, resp_tag[TAG_W +: TAG_W]);
        else passes++;
        req_valid = 2'b10;
        tick();
        req_valid = '0;
        checks++;
        if ({resp_hit, wb_cyc_o} !== 3'b10_0) $display("FAIL retry_single_fill: got h=%b cyc=%b required 10 0", resp_hit, wb_cyc_o);
        else passes++;
    endtask

    task automatic test_error();
        int lat;
        req_vpn = {20'h0, 20'h0DEAD}; req_valid = 2'b01;
        tick();
        req_valid = '0;
        wb_respond(1, 1, 32'hFFFF_FFFF);
        wait_resp(lat);
        checks++;
        if ({resp_valid, resp_hit, resp_fault, resp_tag} !== {6'b01_00_01, 52'h0})
            $display("FAIL err_resp: got v=%b h=%b f=%b tag=%h required 01 00 01 0", resp_valid, resp_hit, resp_fault, resp_tag);
        else passes++;
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        checks++;
        if ({busy, resp_valid} !== 3'b1_00) $display("FAIL err_relookup: got busy=%b v=%b required 1 00", busy, resp_valid);
        else passes++;
        wb_respond(0, 0, 32'h0000_1000);
        wait_resp(lat);
        checks++;
        if ({resp_valid, resp_hit, resp_fault} !== 6'b01_00_01)
            $display("FAIL pte_invalid: got v=%b h=%b f=%b required 01 00 01", resp_valid, resp_hit, resp_fault);
        else passes++;
    endtask

    task automatic test_flush_fetch();
        int lat;
        logic [31:0] pte = 32'h1234_5671;
        req_vpn = {20'h0, 20'h0BEEF}; req_valid = 2'b01;
        tick();
        req_valid = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wb_respond(0, 0, pte);
        wait_resp(lat);
        checks++;
        if ({resp_valid, resp_hit, resp_tag[0 +: TAG_W]} !== {4'b0101, pte[31:10], pte[3:0]})
            $display("FAIL flush_resp: got v=%b h=%b tag=%h", resp_valid, resp_hit, resp_tag[0 +: TAG_W]);
        else passes++;
        req_vpn = {20'h0ABCD, 20'h0BEEF}; req_valid = 2'b11;
        tick();
        req_valid = '0;
        checks++;
        if ({resp_valid, busy} !== 3'b00_1) $display("FAIL flush_miss: got v=%b busy=%b required 00 1", resp_valid, busy);
        else passes++;
        checks++;
        if (wb_adr_o !== 32'h0002AF34) $display("FAIL rr_port: got adr=%h required 0002af34", wb_adr_o);
        else passes++;
        wb_respond(0, 0, 32'h0000_0401);
        wait_resp(lat);
        checks++;
        if ({resp_valid, resp_hit} !== 4'b1010) $display("FAIL rr_resp: got v=%b h=%b required 10 10", resp_valid, resp_hit);
        else passes++;
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 80; t++) begin
            logic [PORTS-1:0]       v, exp_hit, exp_v;
            logic [PORTS*TAG_W-1:0] exp_tag;
            logic [VPN_W-1:0]       pv [PORTS];
            logic [31:0]            pte;
            int victim, term, lat, idx;
            v = PORTS'($urandom_range(1, 3));
            exp_hit = '0; exp_tag = '0; victim = -1;
            for (int p = 0; p < PORTS; p++) begin
                pv[p] = VPN_W'(20'h40000 + $urandom_range(0, 23));
                req_vpn[p*VPN_W +: VPN_W] = pv[p];
                idx = model_find(pv[p]);
                if (v[p] && idx >= 0) begin exp_hit[p] = 1'b1; exp_tag[p*TAG_W +: TAG_W] = m_tag[idx]; end
            end
            for (int i = 1; i <= PORTS; i++)
                if (victim < 0 && v[(m_last + i) % PORTS] && !exp_hit[(m_last + i) % PORTS]) victim = (m_last + i) % PORTS;
            req_valid = v;
            tick();
            req_valid = '0;
            checks++;
            if ({resp_valid, resp_hit, resp_fault, resp_tag, busy} !== {exp_hit, exp_hit, 2'b00, exp_tag, victim >= 0})
                $display("FAIL rnd_lookup_%0d: got v=%b h=%b busy=%b tag=%h required h=%b busy=%b tag=%h",
                         t, resp_valid, resp_hit, busy, resp_tag, exp_hit, victim >= 0, exp_tag);
            else passes++;
            if (victim >= 0) begin
                m_last = victim;
                pte = pte_of(pv[victim]);
                term = ($urandom_range(0, 9) == 0) ? 1 : 0;
                checks++;
                if (wb_adr_o !== {10'b0, pv[victim], 2'b00}) $display("FAIL rnd_adr_%0d: got %h vpn %h", t, wb_adr_o, pv[victim]);
                else passes++;
                wb_respond($urandom_range(0, 3), term, pte);
                wait_resp(lat);
                exp_v = '0; exp_v[victim] = 1'b1;
                exp_tag = '0;
                if (term == 0 && pte[0]) begin
                    exp_tag[victim*TAG_W +: TAG_W] = {pte[31:10], pte[3:0]};
                    model_fill(pv[victim], pte);
                    exp_hit = exp_v;
                end else begin
                    exp_hit = '0;
                end
                checks++;
                if ({resp_valid, resp_hit, resp_fault, resp_tag} !== {exp_v, exp_hit, exp_v & ~exp_hit, exp_tag})
                    $display("FAIL rnd_refill_%0d: got v=%b h=%b f=%b tag=%h required v=%b h=%b tag=%h",
                             t, resp_valid, resp_hit, resp_fault, resp_tag, exp_v, exp_hit, exp_tag);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_multi_hit();
        test_rst_refill();
        test_replacement();
        test_retry();
        test_error();
        test_flush_fetch();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
